// File: rtl/demo_scene_sequencer.sv
// Frame-driven demo timeline: sub-beat, beat and part counters plus
// derived cues (envelope, accent, title) with pause, skip and restart.
module demo_scene_sequencer #(
  parameter int FRAMES_PER_BEAT = 16,
  parameter int BEATS_PER_PART  = 8,
  parameter int NUM_PARTS       = 8,
  parameter int LOOP            = 1,
  localparam int SW = $clog2(FRAMES_PER_BEAT),
  localparam int BW = $clog2(BEATS_PER_PART),
  localparam int FW = SW + BW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_tick,
  input  logic          pause,
  input  logic          skip,
  input  logic          restart,
  output logic [SW-1:0] sub_frame,
  output logic [BW-1:0] beat,
  output logic [2:0]    part,
  output logic [FW-1:0] frame,
  output logic [4:0]    envelope,
  output logic          accent,
  output logic          beat_pulse,
  output logic          part_pulse,
  output logic          title_en,
  output logic          paused,
  output logic          done
);

  typedef enum logic [1:0] {RUN, PAUSED, DONE} state_t;

  localparam logic [2:0] LAST = 3'(NUM_PARTS - 1);

  state_t        state_q, state_d;
  logic [SW-1:0] sub_q, sub_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [2:0]    part_q, part_d;
  logic          bp_q, bp_d;
  logic          pp_q, pp_d;
  logic          last_part;
  logic [2:0]    part_inc;
  state_t        hold;

  assign last_part = (part_q == LAST);
  assign part_inc  = last_part ? 3'd0 : part_q + 3'd1;
  assign hold      = pause ? PAUSED : RUN;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      sub_q   <= '0;
      beat_q  <= '0;
      part_q  <= '0;
      bp_q    <= 1'b0;
      pp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sub_q   <= sub_d;
      beat_q  <= beat_d;
      part_q  <= part_d;
      bp_q    <= bp_d;
      pp_q    <= pp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    beat_d  = beat_q;
    part_d  = part_q;
    bp_d    = 1'b0;
    pp_d    = 1'b0;
    if (state_q != DONE) state_d = hold;
    if (restart) begin
      sub_d   = '0;
      beat_d  = '0;
      part_d  = '0;
      pp_d    = 1'b1;
      state_d = hold;
    end else if (skip && state_q != DONE) begin
      // Without looping, skipping past the end freezes on the last part.
      if (last_part && LOOP == 0) begin
        state_d = DONE;
      end else begin
        sub_d  = '0;
        beat_d = '0;
        part_d = part_inc;
        pp_d   = 1'b1;
      end
    end else if (frame_tick && state_q == RUN && !pause) begin
      if (sub_q == '1 && beat_q == '1 && last_part && LOOP == 0) begin
        state_d = DONE;
      end else begin
        sub_d = sub_q + 1'b1;
        if (sub_q == '1) begin
          beat_d = beat_q + 1'b1;
          bp_d   = 1'b1;
          if (beat_q == '1) begin
            part_d = part_inc;
            pp_d   = 1'b1;
          end
        end
      end
    end
  end

  assign sub_frame  = sub_q;
  assign beat       = beat_q;
  assign part       = part_q;
  assign frame      = {beat_q, sub_q};
  assign envelope   = 5'd31 - 5'({sub_q, 1'b0});
  assign accent     = (beat_q[1:0] == 2'b10);
  assign beat_pulse = bp_q;
  assign part_pulse = pp_q;
  // Frame length is a power of two: top two bits set means >= 3/4.
  assign title_en   = (part_q == 3'd0) ||
                      (last_part && frame[FW-1 -: 2] == 2'b11);
  assign paused     = (state_q == PAUSED);
  assign done       = (state_q == DONE);

endmodule
